mu_widthadapt_1_to_n: RTL and testbench
=======================================

MU_WIDTHADAPT_1_TO_N -- requirements
Module: mu_widthadapt_1_to_n

Interface
REQ-001 SHALL have parameter IW, default 16: input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4: input beats per output word; legal range 2..16.
REQ-003 SHALL have parameter SWAP, default 0: 0 puts the first beat in the most-significant lane; 1 puts it in the least-significant lane.
REQ-004 SHALL derive OW = IW*RATIO and CW = $clog2(RATIO+1) internally; neither SHALL be user-overridable.
REQ-005 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port wr_data  in  IW: input beat.
REQ-008 SHALL have port wr_valid  in  1: input beat valid.
REQ-009 SHALL have port wr_ready  out  1: input beat accepted this cycle when high together with wr_valid.
REQ-010 SHALL have port flush  in  1: request to emit a partially filled word.
REQ-011 SHALL have port rd_data  out  OW: assembled output word.
REQ-012 SHALL have port rd_valid  out  1: output word valid.
REQ-013 SHALL have port rd_ready  in  1: output word consumed this cycle when high together with rd_valid.
REQ-014 SHALL have port rd_count  out  CW: number of real beats in rd_data (RATIO for a full word).

Function
REQ-015 SHALL keep a lane counter cnt (0..RATIO-1) and operate in three states: EMPTY (cnt=0, rd_valid=0), FILL (cnt>0, rd_valid=0), HOLD (rd_valid=1).
REQ-016 SHALL drive wr_ready = !rd_valid || rd_ready as a combinational function; the path from rd_ready to wr_ready SHALL contain no register.
REQ-017 SHALL, on an accepted beat in EMPTY or FILL, write wr_data into lane cnt as counted from the first-beat end selected by SWAP, and SHALL hold all unfilled lanes at zero.
REQ-018 SHALL, when the accepted beat fills lane RATIO-1, enter HOLD on the next edge with rd_count=RATIO and cnt=0.
REQ-019 SHALL, in HOLD with rd_ready=1 and an accepted beat, start a new word with that beat (cnt=1, FILL) and clear all other lanes to zero, giving one output word per RATIO input beats with no bubble cycles.
REQ-020 SHALL, in HOLD with rd_ready=1 and no beat, return to EMPTY.
REQ-021 SHALL hold rd_data and rd_count stable while rd_valid=1 and rd_ready=0.
REQ-022 SHALL, with flush=1 in FILL, enter HOLD on the next edge with rd_count equal to the number of beats held (including any beat accepted in the same cycle) and with lanes placed as if the remaining beats were zero.
REQ-023 SHALL treat a flush that coincides with the accepted beat that completes a word as a normal full word (rd_count=RATIO).
REQ-024 SHALL ignore flush in EMPTY (no output is produced) and in HOLD.

Reset
REQ-025 SHALL, while rst_n=0, immediately force rd_valid=0, rd_data=0, rd_count=0 and cnt=0 (state EMPTY), independent of clk.
REQ-026 SHALL discard any partial or held word when reset asserts mid-operation, and SHALL accept a beat on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL provide flush support when macro MU_WIDTHADAPT_FLUSH_EN is defined, behaving per REQ-022..024.
REQ-028 SHALL, when MU_WIDTHADAPT_FLUSH_EN is undefined, leave the flush input unused, emit only full words, and tie rd_count to the constant RATIO.

Verification (IW=8, RATIO=4)
REQ-029 SHALL cover: SWAP=0, beats 11,22,33,44, rd_ready=1 -> rd_data=0x11223344, rd_count=4, rd_valid high for exactly 1 cycle.
REQ-030 SHALL cover: SWAP=1, same beats -> rd_data=0x44332211.
REQ-031 SHALL cover: wr_valid=1 continuously, rd_ready=1 -> a word every 4 cycles and wr_ready never low.
REQ-032 SHALL cover: word held with rd_ready=0 for 5 cycles -> wr_ready=0, rd_data stable; on rd_ready=1 the next beat is accepted in that same cycle.
REQ-033 SHALL cover (FLUSH_EN, SWAP=0): beats AA,BB then flush -> rd_data=0xAABB0000, rd_count=2; flush in EMPTY -> rd_valid stays 0.
REQ-034 SHALL cover: rst_n pulsed low after 2 beats -> rd_valid=0 asynchronously; the next 4 beats yield a clean full word.

Source files
------------

// File: rtl/mu_widthadapt_1_to_n.sv
// ---------------------------------------------------------------------------
// mu_widthadapt_1_to_n
// Narrow-to-wide width adapter: packs RATIO input beats of IW bits into one
// output word of OW = IW*RATIO bits. A single word register is used both to
// assemble and to present the word; while a word is presented and not taken,
// input is stalled. When the word is taken in the same cycle as a new beat
// arrives, that beat starts the next word, so full-rate streaming has no bubbles.
//
// Parameters
//   IW     input beat width
//   RATIO  beats per output word (2..16)
//   SWAP   0: first beat in the most-significant lane, 1: least-significant
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_data   input beat
//   wr_valid  input beat valid
//   wr_ready  input beat accepted when high with wr_valid (combinational)
//   flush     emit a partially filled word (only with MU_WIDTHADAPT_FLUSH_EN)
//   rd_data   assembled output word
//   rd_valid  output word valid
//   rd_ready  output word consumed when high with rd_valid
//   rd_count  number of real beats in rd_data
//
// Build option
//   MU_WIDTHADAPT_FLUSH_EN  defined: flush emits partial words with a beat
//                           count; undefined: flush is ignored, only full
//                           words are emitted and rd_count is fixed at RATIO.
// ---------------------------------------------------------------------------
module mu_widthadapt_1_to_n #(
    parameter int IW    = 16,
    parameter int RATIO = 4,
    parameter int SWAP  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IW-1:0]                  wr_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic                           flush,
    output logic [IW*RATIO-1:0]            rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [$clog2(RATIO+1)-1:0]     rd_count
);

    localparam int OW = IW * RATIO;
    localparam int CW = $clog2(RATIO + 1);

    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
    localparam logic [CW-1:0] FULL = CW'(RATIO);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [OW-1:0]  data_q, data_d;
    logic           accept;

    // Write one beat into logical lane idx; logical lane 0 is the first-beat
    // end, which is the MSB lane unless SWAP is set.
    function automatic logic [OW-1:0] put_beat(input logic [OW-1:0] word,
                                                input logic [IW-1:0] beat,
                                                input logic [CW-1:0] idx);
        logic [OW-1:0] w;
        int            phys;
        w    = word;
        phys = (SWAP != 0) ? int'(idx) : (RATIO - 1 - int'(idx));
        for (int i = 0; i < RATIO; i++) begin
            if (i == phys) begin
                w[i*IW +: IW] = beat;
            end
        end
        return w;
    endfunction

    assign rd_valid = (state_q == S_HOLD);
    assign wr_ready = !rd_valid || rd_ready;
    assign accept   = wr_valid && wr_ready;
    assign rd_data  = data_q;

`ifdef MU_WIDTHADAPT_FLUSH_EN
    logic [CW-1:0]  rcnt_q, rcnt_d;
    logic           flush_act;

    // Flush only has an effect on a partially filled word.
    assign flush_act = flush && (state_q == S_FILL);
    assign rd_count  = rcnt_q;
`else
    logic           unused_flush;

    assign unused_flush = flush;
    assign rd_count     = FULL;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef MU_WIDTHADAPT_FLUSH_EN
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            S_EMPTY, S_FILL: begin
                if (accept) begin
                    // A fresh word starts from all-zero lanes.
                    data_d = put_beat((state_q == S_FILL) ? data_q : '0, wr_data, cnt_q);
                    if (cnt_q == LAST) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
`ifdef MU_WIDTHADAPT_FLUSH_EN
                        rcnt_d  = FULL;
`endif
                    end else begin
                        state_d = S_FILL;
                        cnt_d   = cnt_q + CW'(1);
`ifdef MU_WIDTHADAPT_FLUSH_EN
                        if (flush_act) begin
                            state_d = S_HOLD;
                            cnt_d   = '0;
                            rcnt_d  = cnt_q + CW'(1);
                        end
`endif
                    end
                end
`ifdef MU_WIDTHADAPT_FLUSH_EN
                else if (flush_act) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    rcnt_d  = cnt_q;
                end
`endif
            end
            S_HOLD: begin
                if (rd_ready) begin
                    if (accept) begin
                        // Word taken and next beat arrives together: beat
                        // becomes lane 0 of a new, otherwise-zero word.
                        data_d  = put_beat('0, wr_data, '0);
                        cnt_d   = CW'(1);
                        state_d = S_FILL;
                    end else begin
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = S_EMPTY;
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
                cnt_d   = '0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef MU_WIDTHADAPT_FLUSH_EN
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef MU_WIDTHADAPT_FLUSH_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mu_widthadapt_1_to_n.sv
// ---------------------------------------------------------------------------
// tb_mu_widthadapt_1_to_n
// Directed bench for mu_widthadapt_1_to_n with IW=8, RATIO=4. Two instances
// share all inputs: u_msb (SWAP=0) and u_lsb (SWAP=1).
// ---------------------------------------------------------------------------
module tb_mu_widthadapt_1_to_n;

    localparam int IW    = 8;
    localparam int RATIO = 4;
    localparam int OW    = IW * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

`ifdef MU_WIDTHADAPT_FLUSH_EN
    localparam logic [CW-1:0] RST_CNT = '0;
`else
    localparam logic [CW-1:0] RST_CNT = CW'(RATIO);
`endif

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] wr_data;
    logic          wr_valid;
    logic          flush;
    logic          rd_ready;

    logic          wr_ready0, wr_ready1;
    logic [OW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
    logic [CW-1:0] rd_count0, rd_count1;

    int errors = 0;
    int checks = 0;

    mu_widthadapt_1_to_n #(.IW(IW), .RATIO(RATIO), .SWAP(0)) u_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready0),
        .flush    (flush),
        .rd_data  (rd_data0),
        .rd_valid (rd_valid0),
        .rd_ready (rd_ready),
        .rd_count (rd_count0)
    );

    mu_widthadapt_1_to_n #(.IW(IW), .RATIO(RATIO), .SWAP(1)) u_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready1),
        .flush    (flush),
        .rd_data  (rd_data1),
        .rd_valid (rd_valid1),
        .rd_ready (rd_ready),
        .rd_count (rd_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_data  = '0;
        wr_valid = 1'b0;
        flush    = 1'b0;
        rd_ready = 1'b1;

        // Reset state
        #3;
        check("rst_valid", 32'(rd_valid0), 32'd0);
        check("rst_data", rd_data0, 32'h0);
        check("rst_count", 32'(rd_count0), 32'(RST_CNT));
        check("rst_wr_ready", 32'(wr_ready0), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic word, both lane orders, valid for exactly one cycle
        beat(8'h11);
        beat(8'h22);
        beat(8'h33);
        check("basic_not_yet", 32'(rd_valid0), 32'd0);
        beat(8'h44);
        wr_valid = 1'b0;
        check("basic_valid", 32'(rd_valid0), 32'd1);
        check("basic_msb_data", rd_data0, 32'h11223344);
        check("basic_lsb_data", rd_data1, 32'h44332211);
        check("basic_count", 32'(rd_count0), 32'd4);
        tick();
        check("basic_one_cycle", 32'(rd_valid0), 32'd0);

        // Continuous streaming: one word per four beats, never stalled
        for (int k = 1; k <= 8; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(k);
            #1;
            check($sformatf("stream_wr_ready_%0d", k), 32'(wr_ready0), 32'd1);
            tick();
            check($sformatf("stream_valid_%0d", k), 32'(rd_valid0), (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k == 4) check("stream_word1", rd_data0, 32'h01020304);
            if (k == 8) check("stream_word2", rd_data0, 32'h05060708);
        end
        wr_valid = 1'b0;
        tick();
        check("stream_drain", 32'(rd_valid0), 32'd0);

        // Backpressure: word held five cycles, then released with a beat
        rd_ready = 1'b0;
        beat(8'hA1);
        beat(8'hA2);
        beat(8'hA3);
        beat(8'hA4);
        wr_data = 8'hB1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_wr_ready_%0d", k), 32'(wr_ready0), 32'd0);
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(rd_valid0), 32'd1);
            check($sformatf("bp_data_%0d", k), rd_data0, 32'hA1A2A3A4);
        end
        rd_ready = 1'b1;
        #1;
        check("bp_release_wr_ready", 32'(wr_ready0), 32'd1);
        tick();
        check("bp_release_valid", 32'(rd_valid0), 32'd0);
        beat(8'hB2);
        beat(8'hB3);
        beat(8'hB4);
        wr_valid = 1'b0;
        check("bp_next_valid", 32'(rd_valid0), 32'd1);
        check("bp_next_data", rd_data0, 32'hB1B2B3B4);
        tick();

`ifdef MU_WIDTHADAPT_FLUSH_EN
        // Flush of a two-beat partial word
        beat(8'hAA);
        beat(8'hBB);
        wr_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", 32'(rd_valid0), 32'd1);
        check("flush_msb_data", rd_data0, 32'hAABB0000);
        check("flush_lsb_data", rd_data1, 32'h0000BBAA);
        check("flush_count", 32'(rd_count0), 32'd2);
        tick();
        check("flush_done", 32'(rd_valid0), 32'd0);

        // Flush while empty produces nothing
        flush = 1'b1;
        tick();
        check("flush_empty_1", 32'(rd_valid0), 32'd0);
        tick();
        check("flush_empty_2", 32'(rd_valid0), 32'd0);
        flush = 1'b0;

        // Flush together with a beat counts that beat
        beat(8'h12);
        flush = 1'b1;
        beat(8'h34);
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_beat_count", 32'(rd_count0), 32'd2);
        check("flush_beat_data", rd_data0, 32'h12340000);
        tick();

        // Flush with the completing beat is an ordinary full word
        beat(8'hCC);
        beat(8'hDD);
        beat(8'hEE);
        flush = 1'b1;
        beat(8'hFF);
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_full_count", 32'(rd_count0), 32'd4);
        check("flush_full_data", rd_data0, 32'hCCDDEEFF);
        tick();
`endif

        // Asynchronous reset while a word is held
        rd_ready = 1'b0;
        beat(8'h91);
        beat(8'h92);
        beat(8'h93);
        beat(8'h94);
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_hold_valid", 32'(rd_valid0), 32'd0);
        check("arst_hold_data", rd_data0, 32'h0);
        rst_n    = 1'b1;
        rd_ready = 1'b1;

        // Reset after two beats discards the partial word
        tick();
        beat(8'h55);
        beat(8'h66);
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("arst_partial_valid", 32'(rd_valid0), 32'd0);
        rst_n = 1'b1;
        beat(8'h01);
        beat(8'h02);
        beat(8'h03);
        beat(8'h04);
        wr_valid = 1'b0;
        check("arst_clean_valid", 32'(rd_valid0), 32'd1);
        check("arst_clean_data", rd_data0, 32'h01020304);
        check("arst_clean_count", 32'(rd_count0), 32'd4);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
